// File: rtl/video_pkg.sv
// video_pkg: 480x272 mode constants, playfield grid geometry and lock states
package video_pkg;
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;
  localparam int CELL_X0 = 16;
  localparam int CELL_Y0 = 16;
  localparam int COLS = 20;
  localparam int ROWS = 10;
  localparam int CELL_SZ = 16;
  localparam logic [7:0] LUMA_TH = 8'h80;
  typedef enum logic [1:0] {UNLOCK, CAND, LOCK} lock_e;
endpackage

// File: rtl/video_if.sv
// video_if: parallel RGB video stream with sync and data enable
interface video_if;
  logic hs, vs, de;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  modport master(output hs, vs, de, rgb_r, rgb_g, rgb_b);
  modport slave(input hs, vs, de, rgb_r, rgb_g, rgb_b);
endinterface

// File: rtl/video_cell_sampler.sv
// video_cell_sampler: samples each grid cell centre and thresholds it into an occupancy bit
module video_cell_sampler #(
  parameter int CELL_X0 = video_pkg::CELL_X0,
  parameter int CELL_Y0 = video_pkg::CELL_Y0,
  parameter int COLS = video_pkg::COLS,
  parameter int ROWS = video_pkg::ROWS,
  parameter logic [7:0] LUMA_TH = video_pkg::LUMA_TH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        cell_valid,
  output logic [3:0]  cell_row,
  output logic [4:0]  cell_col,
  output logic        cell_bit
);
  import video_pkg::*;
  logic [11:0] dx, dy;
  logic hit;
  // unsigned offsets wrap below the origin, so one compare covers both grid bounds
  always_comb begin
    dx = x - 12'(CELL_X0);
    dy = y - 12'(CELL_Y0);
    hit = de && dx < 12'(CELL_SZ * COLS) && dy < 12'(CELL_SZ * ROWS) && dx[3:0] == 4'd8 && dy[3:0] == 4'd8;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cell_valid <= 1'b0;
      cell_row <= '0;
      cell_col <= '0;
      cell_bit <= 1'b0;
    end else begin
      cell_valid <= hit;
      if (hit) begin
        cell_col <= dx[8:4];
        cell_row <= dy[7:4];
        cell_bit <= r >= LUMA_TH && g >= LUMA_TH && b >= LUMA_TH;
      end
    end
endmodule

// File: rtl/video_capture.sv
// video_capture: recovers pixel coordinates, measures geometry, tracks lock and decodes the playfield
module video_capture #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter logic HS_POL = video_pkg::HS_POL,
  parameter logic VS_POL = video_pkg::VS_POL,
  parameter int CELL_X0 = video_pkg::CELL_X0,
  parameter int CELL_Y0 = video_pkg::CELL_Y0,
  parameter int COLS = video_pkg::COLS,
  parameter int ROWS = video_pkg::ROWS,
  parameter logic [7:0] LUMA_TH = video_pkg::LUMA_TH
) (
  input  logic        clk,
  input  logic        rst_n,
  video_if.slave      vid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_valid,
  output logic        locked,
  output logic [11:0] meas_width,
  output logic [11:0] meas_lines,
  output logic        cell_valid,
  output logic [3:0]  cell_row,
  output logic [4:0]  cell_col,
  output logic        cell_bit,
  output logic        frame_done,
  output logic        geom_err
);
  import video_pkg::*;
  logic hs1, vs1, de1, hs2, vs2, de2;
  logic [7:0] r1, g1, b1;
  logic [11:0] run;
  logic seen, wbad, lbad, vbad;
  logic vs_lead, hs_lead, de_fall, good;
  lock_e state, state_nx;
  always_comb begin
    vs_lead = vs1 == VS_POL && vs2 != VS_POL;
    hs_lead = hs1 == HS_POL && hs2 != HS_POL;
    de_fall = !de1 && de2;
    good = seen && pix_y == 12'(V_ACTIVE) && !wbad && !lbad && !vbad;
    state_nx = !vs_lead ? state : !good ? UNLOCK : state == UNLOCK ? CAND : LOCK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= UNLOCK;
    else state <= state_nx;
  assign locked = state == LOCK;
  assign pix_valid = de1;
  // pix_x tracks the stage-1 pixel so it lines up with pix_valid and the stage-1 colour
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hs1, hs2} <= {2{!HS_POL}};
      {vs1, vs2} <= {2{!VS_POL}};
      {de1, de2} <= 2'b00;
      {r1, g1, b1} <= '0;
      pix_x <= '0;
      pix_y <= '0;
      run <= '0;
      meas_width <= '0;
      meas_lines <= '0;
      {seen, wbad, lbad, vbad} <= 4'b0000;
      frame_done <= 1'b0;
      geom_err <= 1'b0;
    end else begin
      {hs1, vs1, de1} <= {vid.hs, vid.vs, vid.de};
      {r1, g1, b1} <= {vid.rgb_r, vid.rgb_g, vid.rgb_b};
      {hs2, vs2, de2} <= {hs1, vs1, de1};
      if (vid.de) pix_x <= !de1 ? '0 : pix_x == 12'hFFF ? pix_x : pix_x + 12'd1;
      pix_y <= vs_lead ? '0 : de_fall ? pix_y + 12'd1 : pix_y;
      run <= de1 ? (de2 ? run + 12'd1 : 12'd1) : run;
      if (de_fall) meas_width <= run;
      if (vs_lead) meas_lines <= pix_y;
      wbad <= !vs_lead && (wbad || (de_fall && run != 12'(H_ACTIVE)));
      lbad <= !vs_lead && (lbad || (hs_lead && de1));
      vbad <= !vs_lead && (vbad || (de1 && vs1 == VS_POL));
      seen <= seen || vs_lead;
      frame_done <= vs_lead;
      geom_err <= geom_err || (vs_lead && state == LOCK && !good);
    end
  video_cell_sampler #(
    .CELL_X0(CELL_X0), .CELL_Y0(CELL_Y0), .COLS(COLS), .ROWS(ROWS), .LUMA_TH(LUMA_TH)
  ) u_cell (
    .clk(clk), .rst_n(rst_n), .de(de1), .x(pix_x), .y(pix_y),
    .r(r1), .g(g1), .b(b1),
    .cell_valid(cell_valid), .cell_row(cell_row), .cell_col(cell_col), .cell_bit(cell_bit)
  );
endmodule
